// File: rtl/anton_neopixel_apb_bridge_pkg.sv
// rtl/anton_neopixel_apb_bridge_pkg.sv - shared FSM encoding, geometry constants and byte-lane helpers
package anton_neopixel_apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int REG_REGION_BIT = 13;
  localparam int APB_LANES      = 4;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    return shifted[7:0];
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/anton_neopixel_apb_bridge.sv
// rtl/anton_neopixel_apb_bridge.sv - APB3 completer driving the neopixel internal byte bus
module anton_neopixel_apb_bridge
  import anton_neopixel_apb_bridge_pkg::*;
#(
  parameter int APB_ADDR_W = 16,
  parameter int BUS_ADDR_W = 14
) (
  input  logic                  busClk,
  input  logic                  busReset,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic                  wide32,
  output logic [BUS_ADDR_W-1:0] busAddr,
  output logic [7:0]            busDataIn,
  output logic                  busWrite,
  output logic                  busRead,
  input  logic [7:0]            busDataOut
);

  state_e                  state_q, state_d;
  logic [APB_ADDR_W-1:2]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic                    wide_q, wide_d;
  logic [1:0]              lane_q, lane_d;
  logic [31:0]             prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [BUS_ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [7:0]              bus_wdata_q, bus_wdata_d;
  logic                    bus_write_q, bus_write_d;
  logic                    bus_read_q, bus_read_d;

  logic                    start_wide;
  logic                    start_err;
  logic [1:0]              last_lane;
  logic                    unused_paddr_lsb;

  // Byte address of one lane: wide accesses expand a word index into four byte slots.
  function automatic logic [BUS_ADDR_W-1:0] byte_addr(input logic [APB_ADDR_W-1:2] a,
                                                      input logic wide, input logic [1:0] lane);
    if (wide) begin
      return {1'b0, a[REG_REGION_BIT-1:2], lane};
    end
    return a;
  endfunction

  assign unused_paddr_lsb = ^PADDR[1:0];
  assign start_wide = wide32 && !PADDR[APB_ADDR_W-1];
  assign start_err  = start_wide && (PADDR[APB_ADDR_W-2:REG_REGION_BIT] != '0);
  assign last_lane  = wide_q ? 2'(APB_LANES - 1) : 2'd0;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    wide_d      = wide_q;
    lane_d      = lane_q;
    prdata_d    = prdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_write_d = 1'b0;
    bus_read_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (PSEL && PENABLE && !pready_q) begin
          addr_d  = PADDR[APB_ADDR_W-1:2];
          wdata_d = PWDATA;
          write_d = PWRITE;
          wide_d  = start_wide;
          lane_d  = 2'd0;
          if (start_err) begin
            state_d   = ST_DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else begin
            state_d     = ST_ISSUE;
            bus_addr_d  = byte_addr(PADDR[APB_ADDR_W-1:2], start_wide, 2'd0);
            bus_wdata_d = PWDATA[7:0];
            bus_write_d = PWRITE;
            bus_read_d  = !PWRITE;
          end
        end
      end

      ST_ISSUE: begin
        // The byte returned now belongs to the strobe of the previous cycle.
        if (!write_q && lane_q != 2'd0) begin
          prdata_d = insert_byte(prdata_q, lane_q - 2'd1, busDataOut);
        end
        if (lane_q == last_lane) begin
          state_d  = write_q ? ST_DONE : ST_CAPT;
          pready_d = write_q;
        end else begin
          lane_d      = lane_q + 2'd1;
          bus_addr_d  = byte_addr(addr_q, wide_q, lane_d);
          bus_wdata_d = byte_of(wdata_q, lane_d);
          bus_write_d = write_q;
          bus_read_d  = !write_q;
        end
      end

      ST_CAPT: begin
        if (wide_q) begin
          prdata_d = insert_byte(prdata_q, last_lane, busDataOut);
        end else begin
          prdata_d = {24'h0, busDataOut};
        end
        state_d  = ST_DONE;
        pready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge busClk or posedge busReset) begin
    if (busReset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      wide_q      <= 1'b0;
      lane_q      <= 2'd0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_write_q <= 1'b0;
      bus_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      wide_q      <= wide_d;
      lane_q      <= lane_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_write_q <= bus_write_d;
      bus_read_q  <= bus_read_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign busAddr   = bus_addr_q;
  assign busDataIn = bus_wdata_q;
  assign busWrite  = bus_write_q;
  assign busRead   = bus_read_q;

endmodule

// File: tb/tb_anton_neopixel_apb_bridge.sv
// tb/tb_anton_neopixel_apb_bridge.sv - randomized APB traffic against a transaction-level bridge model
module tb_anton_neopixel_apb_bridge;

  logic        busClk = 1'b0;
  logic        busReset;
  logic        PSEL, PENABLE, PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        wide32;
  logic [13:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite, busRead;
  logic [7:0]  busDataOut;

  always #5 busClk = ~busClk;

  anton_neopixel_apb_bridge dut (
    .busClk(busClk), .busReset(busReset),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .wide32(wide32),
    .busAddr(busAddr), .busDataIn(busDataIn), .busWrite(busWrite), .busRead(busRead),
    .busDataOut(busDataOut)
  );

  int nchecks = 0;
  int nerrors = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [13:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd37;
    return t ^ {2'b00, a[13:8]};
  endfunction

  // Byte-bus peripheral: registered read data, as the real pixel buffer behaves.
  logic [7:0] slave_mem [0:16383];
  bit         slave_wr  [0:16383];
  always @(posedge busClk) begin
    if (busWrite) begin
      slave_mem[busAddr] <= busDataIn;
      slave_wr[busAddr]  <= 1'b1;
    end
    if (busRead) begin
      busDataOut <= slave_wr[busAddr] ? slave_mem[busAddr] : init_byte(busAddr);
    end
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic        rdy;
    logic        err;
    logic [13:0] addr;
    logic [7:0]  data;
    logic [31:0] prdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model_mem [0:16383];
  logic [31:0] last_prdata = 32'h0;

  function automatic exp_t mk(input logic wr, input logic rd, input logic rdy, input logic err,
                              input logic [13:0] addr, input logic [7:0] data, input logic [31:0] prdata);
    exp_t e;
    e.wr = wr; e.rd = rd; e.rdy = rdy; e.err = err;
    e.addr = addr; e.data = data; e.prdata = prdata;
    return e;
  endfunction

  // Builds the cycle-by-cycle expectation of one accepted transfer from the address map rules.
  task automatic model_push(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                            input logic w32, output int exp_lat);
    bit          wide;
    int          n;
    logic [13:0] ba;
    logic [7:0]  b;
    logic [31:0] rd;
    wide = w32 && !a[15];
    if (wide && a[14:13] != 2'b00) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 14'h0, 8'h0, 32'h0));
      last_prdata = 32'h0;
      exp_lat = 1;
      return;
    end
    n  = wide ? 4 : 1;
    rd = 32'h0;
    for (int k = 0; k < n; k++) begin
      ba = wide ? 14'(int'(a[12:2]) * 4 + k) : a[15:2];
      b  = 8'(wd >> (8 * k));
      if (wr) model_mem[ba] = b;
      else    rd = rd | (32'(model_mem[ba]) << (8 * k));
      exp_q.push_back(mk(wr, !wr, 1'b0, 1'b0, ba, b, 32'h0));
    end
    if (!wr) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0, 32'h0));
    if (!wr) last_prdata = rd;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 14'h0, 8'h0, last_prdata));
    exp_lat = n + 1 + (wr ? 0 : 1);
  endtask

  exp_t cur;
  always @(negedge busClk) begin
    if (cmp_en && !busReset) begin
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        chk("busWrite", 32'(busWrite), 32'(cur.wr));
        chk("busRead", 32'(busRead), 32'(cur.rd));
        chk("PREADY", 32'(PREADY), 32'(cur.rdy));
        if (cur.wr || cur.rd) chk("busAddr", 32'(busAddr), 32'(cur.addr));
        if (cur.wr) chk("busDataIn", 32'(busDataIn), 32'(cur.data));
        if (cur.rdy) begin
          chk("PSLVERR", 32'(PSLVERR), 32'(cur.err));
          chk("PRDATA", PRDATA, cur.prdata);
        end
      end else begin
        chk("idle_busWrite", 32'(busWrite), 32'h0);
        chk("idle_busRead", 32'(busRead), 32'h0);
        chk("idle_PREADY", 32'(PREADY), 32'h0);
      end
      chk("strobe_exclusive", 32'(busWrite && busRead), 32'h0);
    end
  end

  task automatic apb(input logic wr, input logic [15:0] a, input logic [31:0] wd, input logic w32,
                     input bit drop, output int lat, output logic [31:0] rdata, output logic err);
    int  elat;
    bit  seen;
    @(posedge busClk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; wide32 = w32;
    @(posedge busClk); #1;
    PENABLE = 1'b1;
    @(posedge busClk);
    model_push(wr, a, wd, w32, elat);
    #1;
    wide32 = 1'($urandom_range(0, 1));
    if (drop) begin
      PSEL = 1'b0; PENABLE = 1'b0;
      PWRITE = 1'($urandom_range(0, 1)); PADDR = 16'($urandom); PWDATA = $urandom;
    end
    lat = 1; rdata = 32'h0; err = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge busClk);
      if (PREADY) begin
        rdata = PRDATA; err = PSLVERR; seen = 1'b1;
        break;
      end
      @(posedge busClk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    if (!seen) exp_q.delete();
    @(posedge busClk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] a;

    for (int i = 0; i < 16384; i++) model_mem[i] = init_byte(14'(i));
    busReset = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0; PWDATA = 32'h0; wide32 = 1'b0;

    @(negedge busClk);
    chk("rst_PREADY", 32'(PREADY), 32'h0);
    chk("rst_PSLVERR", 32'(PSLVERR), 32'h0);
    chk("rst_busWrite", 32'(busWrite), 32'h0);
    chk("rst_busRead", 32'(busRead), 32'h0);
    chk("rst_PRDATA", PRDATA, 32'h0);
    chk("rst_busAddr", 32'(busAddr), 32'h0);
    chk("rst_busDataIn", 32'(busDataIn), 32'h0);
    repeat (2) @(posedge busClk);
    #1 busReset = 1'b0;
    cmp_en = 1'b1;

    apb(1'b1, 16'h0010, 32'h000000A5, 1'b0, 1'b0, lat, rdata, err);
    chk("narrow_wr_latency", 32'(lat), 32'd2);

    apb(1'b1, 16'h8008, 32'h0000001F, 1'b0, 1'b0, lat, rdata, err);
    apb(1'b0, 16'h8008, 32'h0, 1'b0, 1'b0, lat, rdata, err);
    chk("narrow_rd_latency", 32'(lat), 32'd3);
    chk("narrow_rd_data", rdata, 32'h0000001F);
    chk("narrow_rd_err", 32'(err), 32'h0);

    apb(1'b1, 16'h0004, 32'h44332211, 1'b1, 1'b0, lat, rdata, err);
    chk("wide_wr_latency", 32'(lat), 32'd5);

    apb(1'b1, 16'h0004, 32'hEFBEADDE, 1'b1, 1'b0, lat, rdata, err);
    apb(1'b0, 16'h0004, 32'h0, 1'b1, 1'b0, lat, rdata, err);
    chk("wide_rd_latency", 32'(lat), 32'd6);
    chk("wide_rd_data", rdata, 32'hEFBEADDE);

    apb(1'b0, 16'h2000, 32'h0, 1'b1, 1'b0, lat, rdata, err);
    chk("err_latency", 32'(lat), 32'd1);
    chk("err_pslverr", 32'(err), 32'h1);
    chk("err_prdata", rdata, 32'h0);

    apb(1'b1, 16'h8000, 32'h00000077, 1'b1, 1'b0, lat, rdata, err);
    chk("reg_region_narrow_latency", 32'(lat), 32'd2);

    apb(1'b1, 16'h0040, 32'h12345678, 1'b1, 1'b1, lat, rdata, err);
    chk("dropped_psel_latency", 32'(lat), 32'd5);

    // Reset in the third lane of a wide write: lanes 0 and 1 have already landed.
    @(posedge busClk); #1;
    cmp_en = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0100; PWDATA = 32'hCAFEBABE; wide32 = 1'b1;
    @(posedge busClk); #1 PENABLE = 1'b1;
    repeat (3) @(posedge busClk);
    #1;
    chk("pre_reset_strobe", 32'(busWrite), 32'h1);
    chk("pre_reset_addr", 32'(busAddr), 32'h102);
    busReset = 1'b1;
    #1;
    chk("abort_busWrite", 32'(busWrite), 32'h0);
    chk("abort_busRead", 32'(busRead), 32'h0);
    chk("abort_busAddr", 32'(busAddr), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    model_mem[14'h100] = 8'hBE;
    model_mem[14'h101] = 8'hBA;
    last_prdata = 32'h0;
    exp_q.delete();
    repeat (3) begin
      @(negedge busClk);
      chk("abort_PREADY", 32'(PREADY), 32'h0);
    end
    @(posedge busClk); #1 busReset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge busClk);
    apb(1'b0, 16'h0100, 32'h0, 1'b1, 1'b0, lat, rdata, err);
    chk("post_reset_latency", 32'(lat), 32'd6);
    chk("post_reset_low_half", 32'(rdata[15:0]), 32'h0000BABE);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0:       a = 16'h8000 | 16'($urandom);
        1:       a = 16'($urandom) & 16'h1FFF;
        2:       a = 16'($urandom);
        default: a = 16'($urandom_range(0, 63));
      endcase
      repeat ($urandom_range(0, 2)) @(posedge busClk);
      apb(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), lat, rdata, err);
    end

    repeat (4) @(posedge busClk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
